// File: rtl/if_fetch_stage_pkg.sv
// Shared fetch-stage definitions: reset PC, NOP word, FSM state codes and IF/ID entry layout.
// IF_ADDR_CHECK_EN (optional) enables misaligned-fetch trapping in if_fetch_stage.
package if_fetch_stage_pkg;

  localparam logic [31:0] PC_INITIAL_DEF = 32'h0000_3000;
  localparam logic [31:0] NOP_INSTR_DEF  = 32'h0000_0000;

  localparam logic [1:0] ST_BOOT  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_STALL = 2'd2;

  typedef struct packed {
    logic        valid;
    logic        addr_err;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc4;
  } if_id_t;

  function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/if_fetch_stage_if_id_reg.sv
// IF/ID boundary register; priority reset > flush > load > hold > bubble.
// A bubble or flush clears valid/addr_err and forces the NOP word; pc fields keep their last value.
module if_id_reg
  import if_fetch_stage_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   flush,
  input  logic   load,
  input  logic   hold,
  input  if_id_t din,
  output if_id_t q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q.valid    <= 1'b0;
      q.addr_err <= 1'b0;
      q.instr    <= NOP_INSTR;
      q.pc       <= 32'd0;
      q.pc4      <= 32'd0;
    end else if (flush || (!load && !hold)) begin
      q.valid    <= 1'b0;
      q.addr_err <= 1'b0;
      q.instr    <= NOP_INSTR;
    end else if (load) begin
      q <= din;
    end
  end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: boot/fetch/stall FSM, imem req/ready handshake, next-PC mux, IF/ID register.
// Define IF_ADDR_CHECK_EN to trap misaligned PCs as error entries instead of fetching them.
module if_fetch_stage
  import if_fetch_stage_pkg::*;
#(
  parameter logic [31:0] PC_INITIAL = PC_INITIAL_DEF,
  parameter logic [31:0] NOP_INSTR  = NOP_INSTR_DEF
) (
  input  logic        clk,
  input  logic        Reset,
  input  logic [31:0] pc_in,
  output logic [31:0] npc_out,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        id_stall,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc4,
  output logic        id_addr_err
);

  logic [1:0] state;
  logic [1:0] state_nxt;
  if_id_t     ifid;
  if_id_t     ifid_din;
  logic       held;
  logic       fetch_slot;
  logic       misaligned;
  logic       transfer;
  logic       err_load;

  // Decode is holding a valid entry: nothing new may be fetched this cycle.
  assign held       = ifid.valid & id_stall;
  assign fetch_slot = (state == ST_FETCH) & ~held & ~redirect_valid & ~Reset;

`ifdef IF_ADDR_CHECK_EN
  assign misaligned = |pc_in[1:0];
`else
  assign misaligned = 1'b0;
`endif

  assign imem_req  = fetch_slot & ~misaligned;
  assign imem_addr = pc_in;
  assign transfer  = imem_req & imem_ready;
  assign err_load  = fetch_slot & misaligned;

  always_comb begin
    ifid_din.valid    = 1'b1;
    ifid_din.addr_err = err_load;
    ifid_din.instr    = err_load ? NOP_INSTR : imem_rdata;
    ifid_din.pc       = pc_in;
    ifid_din.pc4      = pc_plus4(pc_in);
  end

  always_comb begin
    npc_out = pc_in;
    if (Reset)               npc_out = PC_INITIAL;
    else if (redirect_valid) npc_out = redirect_pc;
    else if (transfer)       npc_out = pc_plus4(pc_in);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_BOOT:  state_nxt = ST_FETCH;
      ST_FETCH: if (held) state_nxt = ST_STALL;
      ST_STALL: if (!id_stall) state_nxt = ST_FETCH;
      default:  state_nxt = ST_FETCH;
    endcase
    if (redirect_valid) state_nxt = ST_FETCH;
  end

  always_ff @(posedge clk) begin
    if (Reset) state <= ST_BOOT;
    else       state <= state_nxt;
  end

  if_id_reg #(
    .NOP_INSTR(NOP_INSTR)
  ) u_if_id (
    .clk  (clk),
    .rst  (Reset),
    .flush(redirect_valid),
    .load (transfer | err_load),
    .hold (held),
    .din  (ifid_din),
    .q    (ifid)
  );

  assign id_valid    = ifid.valid;
  assign id_instr    = ifid.instr;
  assign id_pc       = ifid.pc;
  assign id_pc4      = ifid.pc4;
  assign id_addr_err = ifid.addr_err;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: directed scenarios with literal checks plus a per-cycle reference model.
module tb_if_fetch_stage;

  logic        clk = 1'b0;
  logic        Reset = 1'b1;
  logic [31:0] pc_reg = 32'd0;
  logic [31:0] npc_out;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b1;
  logic [31:0] imem_rdata;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic        id_stall = 1'b0;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [31:0] id_pc4;
  logic        id_addr_err;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return {~a[15:0], a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  // The bench plays the PC register and the instruction memory.
  always @(posedge clk) pc_reg <= npc_out;
  assign imem_rdata = instr_of(imem_addr);

  if_fetch_stage dut (
    .clk(clk), .Reset(Reset), .pc_in(pc_reg), .npc_out(npc_out),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .id_stall(id_stall),
    .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc), .id_pc4(id_pc4), .id_addr_err(id_addr_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: the visible IF/ID entry plus two flags describing the idle cycles
  // (first cycle after reset, and the cycle after decode stopped holding an entry).
  logic        m_en = 1'b0;
  logic        m_valid, m_err, m_boot, m_idle;
  logic [31:0] m_instr, m_pc;

  always @(negedge clk) begin
    logic        hold_now, mis, can, e_req, xfer, eload;
    logic [31:0] e_npc;
    hold_now = m_valid && id_stall;
`ifdef IF_ADDR_CHECK_EN
    mis = (pc_reg % 4) != 0;
`else
    mis = 1'b0;
`endif
    can   = !Reset && !m_boot && !m_idle && !hold_now && !redirect_valid;
    e_req = can && !mis;
    xfer  = e_req && imem_ready;
    eload = can && mis;
    if (Reset)               e_npc = 32'h0000_3000;
    else if (redirect_valid) e_npc = redirect_pc;
    else if (xfer)           e_npc = pc_reg + 32'd4;
    else                     e_npc = pc_reg;

    if (m_en) begin
      check("mdl_imem_req", imem_req, e_req);
      check("mdl_imem_addr", imem_addr, pc_reg);
      check("mdl_npc_out", npc_out, e_npc);
      check("mdl_id_valid", id_valid, m_valid);
      check("mdl_id_instr", id_instr, m_instr);
      check("mdl_id_addr_err", id_addr_err, m_err);
      if (m_valid) begin
        check("mdl_id_pc", id_pc, m_pc);
        check("mdl_id_pc4", id_pc4, m_pc + 32'd4);
      end
    end

    if (Reset) begin
      m_valid = 0; m_err = 0; m_instr = 0; m_pc = 0; m_boot = 1; m_idle = 0;
    end else if (redirect_valid) begin
      m_valid = 0; m_err = 0; m_instr = 0; m_boot = 0; m_idle = 0;
    end else if (xfer) begin
      m_valid = 1; m_err = 0; m_instr = instr_of(pc_reg); m_pc = pc_reg; m_boot = 0; m_idle = 0;
    end else if (eload) begin
      m_valid = 1; m_err = 1; m_instr = 0; m_pc = pc_reg; m_boot = 0; m_idle = 0;
    end else if (hold_now) begin
      m_boot = 0; m_idle = 1;
    end else begin
      m_valid = 0; m_err = 0; m_instr = 0; m_boot = 0; m_idle = 0;
    end
    if (Reset) m_en = 1'b1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input string name, input logic [31:0] exp_pc);
    int k = 0;
    do begin
      step();
      k++;
    end while (!id_valid && k < 6);
    check({name, "_valid"}, id_valid, 1'b1);
    check({name, "_pc"}, id_pc, exp_pc);
  endtask

  logic [23:0] pat_rdy = 24'b1101_1110_0111_1011_0110_1111;
  logic [23:0] pat_stl = 24'b0010_0011_0000_1100_0100_0110;

  initial begin
    // 1: reset, then straight-line fetch
    step(); step();
    check("rst_id_valid", id_valid, 1'b0);
    check("rst_id_instr", id_instr, 32'h0);
    check("rst_id_pc", id_pc, 32'h0);
    check("rst_id_pc4", id_pc4, 32'h0);
    check("rst_id_addr_err", id_addr_err, 1'b0);
    check("rst_imem_req", imem_req, 1'b0);
    check("rst_npc", npc_out, 32'h3000);
    Reset = 1'b0;
    #1;
    check("boot_imem_req", imem_req, 1'b0);
    check("boot_npc", npc_out, 32'h3000);
    step(); step();
    check("seq0_valid", id_valid, 1'b1);
    check("seq0_pc", id_pc, 32'h3000);
    check("seq0_pc4", id_pc4, 32'h3004);
    step();
    check("seq1_pc", id_pc, 32'h3004);
    check("seq1_instr", id_instr, instr_of(32'h3004));

    // 2: imem not ready for 3 cycles at 0x3008
    imem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("miss_req", imem_req, 1'b1);
      check("miss_addr", imem_addr, 32'h3008);
      check("miss_npc", npc_out, 32'h3008);
      step();
      check("miss_bubble", id_valid, 1'b0);
    end
    imem_ready = 1'b1;
    step();
    check("miss_done_valid", id_valid, 1'b1);
    check("miss_done_pc", id_pc, 32'h3008);
    check("miss_done_instr", id_instr, instr_of(32'h3008));

    // 3: decode stall for two cycles with 0x3004 held
    redirect_valid = 1'b1; redirect_pc = 32'h3000;
    step();
    redirect_valid = 1'b0;
    step(); step();
    check("pre_stall_pc", id_pc, 32'h3004);
    id_stall = 1'b1;
    #1;
    check("stall_req", imem_req, 1'b0);
    check("stall_npc", npc_out, 32'h3008);
    step();
    check("stall1_pc", id_pc, 32'h3004);
    check("stall1_valid", id_valid, 1'b1);
    step();
    check("stall2_pc", id_pc, 32'h3004);
    check("stall2_req", imem_req, 1'b0);
    id_stall = 1'b0;
    wait_valid("stall_release", 32'h3008);

    // 4: redirect while stalled and imem ready
    id_stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h3100;
    #1;
    check("redir_req", imem_req, 1'b0);
    check("redir_npc", npc_out, 32'h3100);
    step();
    redirect_valid = 1'b0; id_stall = 1'b0;
    check("redir_flush_valid", id_valid, 1'b0);
    check("redir_flush_instr", id_instr, 32'h0);
    wait_valid("redir_target", 32'h3100);

    // 5: reset in the middle of a stall
    id_stall = 1'b1;
    step(); step();
    Reset = 1'b1;
    #1;
    check("rst_stall_npc", npc_out, 32'h3000);
    check("rst_stall_req", imem_req, 1'b0);
    step();
    check("rst_stall_valid", id_valid, 1'b0);
    Reset = 1'b0; id_stall = 1'b0;
    #1;
    check("rst_boot_req", imem_req, 1'b0);
    wait_valid("rst_refetch", 32'h3000);

    // 6: misaligned redirect target
    redirect_valid = 1'b1; redirect_pc = 32'h3102;
    step();
    redirect_valid = 1'b0;
    #1;
`ifdef IF_ADDR_CHECK_EN
    check("mis_req", imem_req, 1'b0);
    check("mis_npc", npc_out, 32'h3102);
    step();
    check("mis_valid", id_valid, 1'b1);
    check("mis_err", id_addr_err, 1'b1);
    check("mis_pc", id_pc, 32'h3102);
    check("mis_instr", id_instr, 32'h0);
`else
    check("mis_req", imem_req, 1'b1);
    check("mis_addr", imem_addr, 32'h3102);
    step();
    check("mis_valid", id_valid, 1'b1);
    check("mis_err", id_addr_err, 1'b0);
    check("mis_pc", id_pc, 32'h3102);
`endif

    // PC wrap at the top of the address space
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect_valid = 1'b0;
    #1;
    check("wrap_npc", npc_out, 32'h0);
    step();
    check("wrap_pc", id_pc, 32'hFFFF_FFFC);
    check("wrap_pc4", id_pc4, 32'h0);

    // mixed ready/stall pattern, with a redirect racing an accepted response
    redirect_valid = 1'b1; redirect_pc = 32'h3000;
    step();
    redirect_valid = 1'b0;
    for (int i = 0; i < 24; i++) begin
      imem_ready = pat_rdy[i];
      id_stall   = pat_stl[i];
      redirect_valid = (i == 12);
      redirect_pc    = 32'h3200;
      step();
    end
    redirect_valid = 1'b0; imem_ready = 1'b1; id_stall = 1'b0;
    step(); step(); step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
